// File: rtl/m_64spi_if.sv
`default_nettype none
// ============================================================================
// Module   : m_64spi_if
// Brief    : Control bus and SPI pin bundle for the 64-bit SPI master.
// Revision : 1.0
// ============================================================================
interface m_64spi_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             SCLK;
    logic             MOSI;
    logic             MISO;
    logic             SS;

    // master: the SPI initiator itself; slave: control logic plus remote peer
    modport master (
        input  start, in, MISO,
        output out, busy, done, SCLK, MOSI, SS
    );

    modport slave (
        output start, in, MISO,
        input  out, busy, done, SCLK, MOSI, SS
    );
endinterface
`default_nettype wire

// File: rtl/m_64spi.sv
`default_nettype none
// ============================================================================
// Module   : m_64spi
// Brief    : SPI mode-0 master exchanging one 64-bit word per start request.
// Revision : 1.0
// ============================================================================
module m_64spi #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 64
) (
    input  logic      clk,
    input  logic      reset,
    m_64spi_if.master bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] c_div_last = CW'(CLK_DIV - 1);
    localparam logic [6:0]    c_last_bit = 7'(WIDTH);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_setup = 3'd1;
    localparam logic [2:0] c_shift = 3'd2;
    localparam logic [2:0] c_hold  = 3'd3;
    localparam logic [2:0] c_gap   = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [6:0]       r_bit_cnt;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_out;
    logic             r_sclk;
    logic             r_ss;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;

    wire w_tick = (r_cnt == c_div_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_out     <= '0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_tx    <= bus.in;
                        r_mosi  <= bus.in[WIDTH-1];
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_setup;
                    end
                end
                c_setup: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_sclk    <= 1'b1;
                        r_rx      <= {r_rx[WIDTH-2:0], bus.MISO};
                        r_bit_cnt <= 7'd1;
                        r_state   <= c_shift;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_shift: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            // After the last rising edge MOSI keeps bit 0 through HOLD
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= c_hold;
                            end else begin
                                r_tx   <= r_tx << 1;
                                r_mosi <= r_tx[WIDTH-2];
                            end
                        end else begin
                            r_sclk    <= 1'b1;
                            r_rx      <= {r_rx[WIDTH-2:0], bus.MISO};
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_hold: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_ss    <= 1'b1;
                        r_out   <= r_rx;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= c_gap;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_gap: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.SCLK = r_sclk;
    assign bus.MOSI = r_mosi;
    assign bus.SS   = r_ss;
endmodule
`default_nettype wire

// File: doc/m_64spi.md
Name: m_64spi

Overview:
SPI master (initiator) for the 64-bit word exchange link. Drives SCLK, SS and MOSI, and samples MISO, so that it talks to the slave-side 64-bit SPI block on the other board. On a start request it sends one 64-bit word MSB-first and simultaneously receives one 64-bit word. It sits between the master-board control logic and the four SPI pins.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal values >= 2. Slave oversampling requires >= 4 on hardware.
WIDTH, 64, bits per transfer; fixed at 64 in this design.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  transfer request; sampled only in IDLE
in  input  64  word to transmit; latched on start acceptance
out  output  64  last received word; updated only on completion
busy  output  1  high from start acceptance to end of GAP
done  output  1  one-cycle pulse when out is updated
SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
MOSI  output  1  master data out, MSB first
MISO  input  1  slave data in
SS  output  1  slave select, active low

Behaviour:
- Reset values: SCLK=0, SS=1, MOSI=0, busy=0, done=0, out=0. State is IDLE; counters are cleared.
- Reset mid-transfer: on the cycle after reset is sampled high, SS=1 and SCLK=0. The partial word is discarded, out is forced to 0, and no done pulse is generated.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - When start=1 at cycle 0, the block captures in into tx_shift.
  - At cycle 1: SS=0, MOSI=in[63], busy=1. Next state is SETUP.
  - start is ignored in every other state, with no queueing.
- SETUP:
  - Waits CLK_DIV cycles with SCLK low.
  - Then drives SCLK=1 and, in that same clk cycle, samples MISO into rx_shift[0], shifting left. Next state is SHIFT.
- SHIFT: a half-period counter toggles SCLK every CLK_DIV cycles.
  - On each falling edge, tx_shift shifts left and MOSI takes the next bit.
  - On each rising edge, MISO is sampled.
  - A 7-bit bit counter counts rising edges.
  - After the 64th rising edge, the following falling edge returns SCLK to 0. MOSI is left at bit 0 (no shift), and the next state is HOLD.
- Timing with D=CLK_DIV, relative to the cycle-0 start:
  - Rising edges fall at cycles 1+D, 1+3D, …, 1+127D.
  - Falling edges fall at cycles 1+2D, …, 1+128D.
  - Exactly 64 SCLK pulses, each high for D cycles and low for D cycles.
- HOLD:
  - SCLK stays 0 for D cycles.
  - At cycle 1+129D: SS=1, out=rx_shift, done=1 for one cycle, MOSI=0. Next state is GAP.
- GAP:
  - SS stays high for D cycles with busy still 1.
  - At cycle 1+130D: busy=0 and state is IDLE.
  - start may be accepted in that same cycle, so back-to-back transfers have an SS-high time of D+1 cycles.
- Data ordering: received bit k (k = 0 first) lands in out[63-k]. MOSI presents in[63] first and in[0] last.
- MISO is used unsynchronized. It is sampled in the clk cycle in which SCLK is driven high, which is mid-bit in mode 0.
- start and reset both high: reset wins.

Test Plan:
1. Reset check: hold reset 3 cycles -> SCLK=0, SS=1, MOSI=0, busy=0, done=0, out=64'h0.
2. Loopback, MISO tied to MOSI, D=4, in=64'h3333333366666666, one start pulse -> exactly 64 SCLK rising edges; done at cycle 517; out=64'h3333333366666666; SS low for cycles 1..516.
3. Slave model, D=2, model returns 64'hA5A5A5A5_0F0F0F0F and checks MOSI, in=64'h0123456789ABCDEF -> model captures 64'h0123456789ABCDEF; out=64'hA5A5A5A50F0F0F0F; SS rises at cycle 259; busy falls at cycle 261.
4. Start while busy: pulse start at cycle 100 with in=64'hFFFF… -> ignored; the transfer still sends the original word; exactly one done pulse.
5. Reset mid-transfer: assert reset after the 20th SCLK rising edge -> next cycle SS=1, SCLK=0, out=0; no done pulse; a subsequent start completes normally.
6. Back-to-back: start held high continuously, D=4 -> second transfer SS falls 5 cycles after the first SS rise; two done pulses 521 cycles apart.
